// File: rtl/dglk_record_pkg.sv
// rtl/dglk_record_pkg.sv - shared widths, ctrl flag layout and ALU bus decode for dglk_record
//
// Purpose: bus, sample and address widths of the RTMQ peripheral slice used by
//          the digital-lock record block, the ctrl flag bus layout, and the
//          register-write hit test used for the pop strobe.
// ALU output bus layout (W_ALU bits, MSB first): {we, addr[W_ADR], data[W_DAT]}
// Ports: none (package).
package dglk_record_pkg;

   localparam int W_ADR = 8;                    // RTMQ register address width
   localparam int W_DAT = 32;                   // RTMQ register data width
   localparam int W_ALU = 1 + W_ADR + W_DAT;    // ALU output bus width
   localparam int W_PBK = 16;                   // sample width
   localparam int W_APB = 4;                    // sample store address width

   // ctrl flag bus as seen by the record block: {r_ena, rd_rst, wr_rst}
   typedef struct packed {
      logic r_ena;
      logic rd_rst;
      logic wr_rst;
   } ctrl_t;

   function automatic logic alu_hit(input logic we, input logic [W_ADR-1:0] adr,
                                    input logic [W_ADR-1:0] base);
      return we && (adr == base);
   endfunction

endpackage

// File: rtl/dglk_record_bram.sv
// rtl/dglk_record_bram.sv - simple dual-port sample store with registered read port
//
// Purpose: block RAM for captured samples. One write port, one read port whose
//          output register only updates on a read enable, so the last read word
//          is held between reads.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset (clears the read register only)
//   we     in   write enable
//   waddr  in   write address [AW]
//   wdata  in   write data [DW]
//   re     in   read enable
//   raddr  in   read address [AW]
//   rdata  out  registered read data [DW], valid the cycle after re
module dglk_record_bram #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/dglk_record.sv
// rtl/dglk_record.sv - digital-lock capture block: record a sample stream, pop it back via RTMQ
//
// Purpose: while enabled, writes one registered sample per cycle into the sample
//          store until it holds 2^W_APB samples; an RTMQ register write to ADDR
//          pops the next stored sample onto rd_dat two cycles later.
// Option:  DGLK_REC_DECIM_EN adds a register at ADDR+1 holding decimation D; in
//          record mode only every (D+1)th accepted cycle writes.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   alu_out  in   RTMQ ALU output bus [W_ALU]
//   ctrl     in   {r_ena, rd_rst, wr_rst}
//   rec_in   in   sample stream [W_PBK]
//   rd_dat   out  last popped sample [W_PBK]
//   rd_vld   out  one-cycle pulse, rd_dat updated
//   full     out  store full, recording stopped
//   count    out  samples written since last wr_rst [W_APB+1]
module dglk_record
   import dglk_record_pkg::*;
#(
   parameter logic [W_ADR-1:0] ADDR = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W_ALU-1:0] alu_out,
   input  logic [2:0]       ctrl,
   input  logic [W_PBK-1:0] rec_in,
   output logic [W_PBK-1:0] rd_dat,
   output logic             rd_vld,
   output logic             full,
   output logic [W_APB:0]   count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REC  = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   localparam int           DEPTH = 1 << W_APB;
   localparam logic [W_APB:0] LAST = (W_APB+1)'(DEPTH - 1);

   // ALU bus fields
   logic             alu_we;
   logic [W_ADR-1:0] alu_adr;
   logic [W_DAT-1:0] alu_dat;
   logic             unused_alu_dat;

   assign alu_we         = alu_out[W_ALU-1];
   assign alu_adr        = alu_out[W_ALU-2 -: W_ADR];
   assign alu_dat        = alu_out[W_DAT-1:0];
   assign unused_alu_dat = ^alu_dat;

   // Input stage: ctrl, sample and pop strobe all registered once on entry
   ctrl_t            ctrl_q;
   logic [W_PBK-1:0] rec_q;
   logic             pop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= '0;
         rec_q  <= '0;
         pop_q  <= 1'b0;
      end else begin
         ctrl_q <= ctrl_t'(ctrl);
         rec_q  <= rec_in;
         pop_q  <= alu_hit(alu_we, alu_adr, ADDR);
      end
   end

   logic [1:0]     state;
   logic [W_APB:0] r_ptr;
   logic           accept;
   logic           wr;
   logic           pop_ok;

   // A cycle is accepted whenever r_ena is seen outside FULL, including the
   // IDLE cycle that enters REC, so N enabled cycles record N samples.
   assign accept = ctrl_q.r_ena && (state != S_FULL) && !ctrl_q.wr_rst;

`ifdef DGLK_REC_DECIM_EN
   localparam logic [W_ADR-1:0] ADDR_D = ADDR + 1'b1;

   logic [W_APB-1:0] decim;
   logic [W_APB-1:0] dcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         decim <= '0;
      end else if (alu_hit(alu_we, alu_adr, ADDR_D)) begin
         decim <= alu_dat[W_APB-1:0];
      end
   end

   // Cleared whenever recording is off, so each IDLE->REC entry writes first.
   always_ff @(posedge clk) begin
      if (rst || ctrl_q.wr_rst || !ctrl_q.r_ena) begin
         dcnt <= '0;
      end else if (accept) begin
         dcnt <= (dcnt == decim) ? '0 : dcnt + 1'b1;
      end
   end

   assign wr = accept && (dcnt == '0);
`else
   assign wr = accept;
`endif

   // Capture FSM and write count; wr_rst overrides any same-cycle write.
   always_ff @(posedge clk) begin
      if (rst || ctrl_q.wr_rst) begin
         state <= S_IDLE;
         count <= '0;
      end else begin
         if (wr) begin
            count <= count + 1'b1;
         end
         case (state)
            S_IDLE, S_REC: begin
               if (wr && (count == LAST)) begin
                  state <= S_FULL;
               end else if (ctrl_q.r_ena) begin
                  state <= S_REC;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_FULL:  state <= S_FULL;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign full = (state == S_FULL);

   // Pop path: empty test against the live count; rd_rst drops a same-cycle pop.
   assign pop_ok = pop_q && !ctrl_q.rd_rst && (r_ptr < count);

   always_ff @(posedge clk) begin
      if (rst || ctrl_q.rd_rst) begin
         r_ptr <= '0;
      end else if (pop_ok) begin
         r_ptr <= r_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld <= 1'b0;
      end else begin
         rd_vld <= pop_ok;
      end
   end

   dglk_record_bram #(
      .DW (W_PBK),
      .AW (W_APB)
   ) u_bram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr),
      .waddr (count[W_APB-1:0]),
      .wdata (rec_q),
      .re    (pop_ok),
      .raddr (r_ptr[W_APB-1:0]),
      .rdata (rd_dat)
   );

endmodule

// File: tb/tb_dglk_record.sv
// tb/tb_dglk_record.sv - directed self-checking bench for dglk_record
module tb_dglk_record;
   import dglk_record_pkg::*;

   localparam logic [W_ADR-1:0] ADDR = 8'h20;

   logic             clk = 1'b0;
   logic             rst;
   logic [W_ALU-1:0] alu_out;
   logic [2:0]       ctrl;
   logic [W_PBK-1:0] rec_in;
   logic [W_PBK-1:0] rd_dat;
   logic             rd_vld;
   logic             full;
   logic [W_APB:0]   count;

   int npass = 0;
   int nchk  = 0;

   always #5 clk = ~clk;

   dglk_record #(.ADDR(ADDR)) dut (
      .clk     (clk),
      .rst     (rst),
      .alu_out (alu_out),
      .ctrl    (ctrl),
      .rec_in  (rec_in),
      .rd_dat  (rd_dat),
      .rd_vld  (rd_vld),
      .full    (full),
      .count   (count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic pop(input bit exp_vld, input logic [15:0] exp_dat, input string tag);
      alu_out = {1'b1, ADDR, W_DAT'(0)};
      tick();
      alu_out = '0;
      chk({tag, "_vld_t1"}, 32'(rd_vld), 32'd0);
      tick();
      chk({tag, "_vld_t2"}, 32'(rd_vld), 32'(exp_vld));
      chk({tag, "_dat"}, 32'(rd_dat), 32'(exp_dat));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; alu_out = '0; ctrl = 3'b000; rec_in = '0;
      tick(); tick();
      chk("rst_rd_dat", 32'(rd_dat), 0);
      chk("rst_rd_vld", 32'(rd_vld), 0);
      chk("rst_full",   32'(full),   0);
      chk("rst_count",  32'(count),  0);
      rst = 1'b0;
      tick();

      // record 5 ramp samples
      for (int i = 0; i < 5; i++) begin
         ctrl = 3'b100; rec_in = W_PBK'(i);
         tick();
      end
      ctrl = 3'b000;
      for (int i = 5; i < 9; i++) begin
         rec_in = W_PBK'(i);
         tick();
      end
      chk("rec5_count", 32'(count), 5);
      chk("rec5_full",  32'(full),  0);
      for (int i = 0; i < 5; i++) begin
         pop(1'b1, 16'(i), $sformatf("rec5_pop%0d", i));
      end
      pop(1'b0, 16'd4, "rec5_pop_empty");

      // fill: r_ena held 30 cycles
      ctrl = 3'b011; tick();
      ctrl = 3'b000; tick();
      chk("wrrst_count", 32'(count), 0);
      for (int i = 0; i < 30; i++) begin
         ctrl = 3'b100; rec_in = W_PBK'(i);
         tick();
         if (i == 15) begin
            chk("fill_count15", 32'(count), 15);
            chk("fill_full15",  32'(full),  0);
         end
         if (i == 16) begin
            chk("fill_count16", 32'(count), 16);
            chk("fill_full16",  32'(full),  1);
         end
      end
      ctrl = 3'b000;
      tick(); tick();
      chk("fill_count", 32'(count), 16);
      chk("fill_full",  32'(full),  1);
      for (int i = 0; i < 16; i++) begin
         pop(1'b1, 16'(i), $sformatf("fill_pop%0d", i));
      end
      pop(1'b0, 16'd15, "fill_pop_empty");

      // wr_rst coinciding with a REC write
      ctrl = 3'b011; tick();
      ctrl = 3'b000; tick();
      chk("clr_full",  32'(full),  0);
      chk("clr_count", 32'(count), 0);
      ctrl = 3'b100; rec_in = 16'd100; tick();
      ctrl = 3'b100; rec_in = 16'd101; tick();
      ctrl = 3'b101; rec_in = 16'd102; tick();
      chk("wrcoll_pre_count", 32'(count), 2);
      ctrl = 3'b000; tick();
      chk("wrcoll_count", 32'(count), 0);
      tick();
      chk("wrcoll_count2", 32'(count), 0);
      pop(1'b0, 16'd15, "wrcoll_pop_empty");

      // rd_rst coinciding with a pop
      for (int i = 0; i < 3; i++) begin
         ctrl = 3'b100; rec_in = W_PBK'(50 + i);
         tick();
      end
      ctrl = 3'b000; tick(); tick();
      chk("rdcoll_count", 32'(count), 3);
      pop(1'b1, 16'd50, "rdcoll_pop0");
      pop(1'b1, 16'd51, "rdcoll_pop1");
      alu_out = {1'b1, ADDR, W_DAT'(0)}; ctrl = 3'b010;
      tick();
      alu_out = '0; ctrl = 3'b000;
      chk("rdcoll_vld_t1", 32'(rd_vld), 0);
      tick();
      chk("rdcoll_vld_t2", 32'(rd_vld), 0);
      chk("rdcoll_dat_held", 32'(rd_dat), 51);
      pop(1'b1, 16'd50, "rdcoll_after");

      // rst one cycle after a pop
      alu_out = {1'b1, ADDR, W_DAT'(0)};
      tick();
      alu_out = '0; rst = 1'b1;
      tick();
      chk("rstpop_vld",   32'(rd_vld), 0);
      chk("rstpop_dat",   32'(rd_dat), 0);
      chk("rstpop_full",  32'(full),   0);
      chk("rstpop_count", 32'(count),  0);
      rst = 1'b0;
      tick();
      pop(1'b0, 16'd0, "rstpop_empty");

`ifdef DGLK_REC_DECIM_EN
      begin
         logic [W_ADR-1:0] addr_d;
         addr_d = ADDR + 8'd1;
         alu_out = {1'b1, addr_d, W_DAT'(2)};
         tick();
         alu_out = '0;
         ctrl = 3'b011; tick();
         ctrl = 3'b000; tick();
         for (int i = 0; i < 9; i++) begin
            ctrl = 3'b100; rec_in = W_PBK'(i);
            tick();
         end
         ctrl = 3'b000; tick(); tick();
         chk("decim_count", 32'(count), 3);
         pop(1'b1, 16'd0, "decim_pop0");
         pop(1'b1, 16'd3, "decim_pop1");
         pop(1'b1, 16'd6, "decim_pop2");
         pop(1'b0, 16'd6, "decim_pop_empty");
      end
`endif

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
